// File: rtl/dac_seq_pkg.sv
// Shared constants for the DAC sequencer and the ADC reader: FSM encoding,
// 16Q48 fixed-point scaling and the 14-bit DAC code range.
package dac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ADD,
        CONV,
        SETTLE,
        WAIT,
        COMPLETE
    } state_t;

    localparam logic [63:0] ONE_16Q48  = 64'h0001_0000_0000_0000;
    localparam int          FRAC_BITS  = $clog2(ONE_16Q48);
    // 1.0 V maps to 8192 counts, so the code is volts >> (48 - 13).
    localparam int          CONV_SHIFT = 35;
    localparam int          CODE_MAX   = 8191;
    localparam int          CODE_MIN   = -8192;

endpackage

// File: rtl/dac_seq_v2code_sat.sv
// Combinational volts-to-code conversion: floor(volts * 8192) clamped to
// the DAC range, with a flag telling whether the clamp engaged.
module v2code_sat
    import dac_seq_pkg::*;
#(
    parameter int SUM_WIDTH = 65,
    parameter int DAC_WIDTH = 14
) (
    input  logic signed [SUM_WIDTH-1:0] sum_i,
    output logic        [DAC_WIDTH-1:0] code_o,
    output logic                        sat_o
);

    localparam logic signed [SUM_WIDTH-1:0] MAX_S = SUM_WIDTH'(CODE_MAX);
    localparam logic signed [SUM_WIDTH-1:0] MIN_S = SUM_WIDTH'(CODE_MIN);

    logic signed [SUM_WIDTH-1:0] shifted;

    always_comb begin
        shifted = sum_i >>> CONV_SHIFT;
        code_o  = shifted[DAC_WIDTH-1:0];
        sat_o   = 1'b0;
        if (shifted > MAX_S) begin
            code_o = DAC_WIDTH'(CODE_MAX);
            sat_o  = 1'b1;
        end else if (shifted < MIN_S) begin
            code_o = DAC_WIDTH'(CODE_MIN);
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/dac_seq.sv
// Calibrated DAC setpoint sequencer: scales a 16Q48 voltage by gain/offset,
// writes the DAC, waits for settling, then triggers and awaits an ADC capture.
module dac_seq
    import dac_seq_pkg::*;
#(
    parameter int FLOAT_WIDTH = 64,
    parameter int DAC_WIDTH   = 14
) (
    input  logic                   ADC_CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic                   SET_VALID,
    input  logic [FLOAT_WIDTH-1:0] SET_VOLTAGE,
    output logic                   SET_READY,
    input  logic [FLOAT_WIDTH-1:0] DAC_CAL_GAIN,
    input  logic [FLOAT_WIDTH-1:0] DAC_CAL_OFFSET,
    input  logic [31:0]            SETTLE_CYCLES,
    input  logic [31:0]            TIMEOUT_CYCLES,
    input  logic                   ADC_DONE,
    output logic [DAC_WIDTH-1:0]   DAC_CODE_OUT,
    output logic                   ADC_START,
    output logic                   DONE,
    output logic                   SAT,
    output logic                   TIMEOUT
);

    localparam int PW = 2 * FLOAT_WIDTH;
    localparam int SW = FLOAT_WIDTH + 1;

    state_t                         state_q, state_d;
    logic signed [FLOAT_WIDTH-1:0]  volt_q, volt_d;
    logic signed [FLOAT_WIDTH-1:0]  gain_q, gain_d;
    logic signed [FLOAT_WIDTH-1:0]  off_q, off_d;
    logic        [31:0]             settle_q, settle_d;
    logic        [31:0]             tmo_q, tmo_d;
    logic        [31:0]             cnt_q, cnt_d;
    logic signed [FLOAT_WIDTH-1:0]  prod_q, prod_d;
    logic signed [SW-1:0]           sum_q, sum_d;
    logic        [DAC_WIDTH-1:0]    code_q, code_d;
    logic                           start_q, start_d;
    logic                           done_q, done_d;
    logic                           sat_q, sat_d;
    logic                           timeout_q, timeout_d;

    logic signed [PW-1:0]           prod_full;
    logic signed [PW-1:0]           prod_shift;
    logic                           prod_ovf;
    logic signed [FLOAT_WIDTH-1:0]  prod_sat;
    logic        [DAC_WIDTH-1:0]    conv_code;
    logic                           conv_sat;

    // Full-precision product realigned to 16Q48; the bits above the kept
    // window must all be sign copies, otherwise the result is clamped.
    assign prod_full  = PW'(volt_q) * PW'(gain_q);
    assign prod_shift = prod_full >>> FRAC_BITS;
    assign prod_ovf   = !((&prod_shift[PW-1:FLOAT_WIDTH-1]) ||
                          (~|prod_shift[PW-1:FLOAT_WIDTH-1]));
    assign prod_sat   = !prod_ovf ? prod_shift[FLOAT_WIDTH-1:0] :
                        prod_full[PW-1] ? {1'b1, {(FLOAT_WIDTH-1){1'b0}}} :
                                          {1'b0, {(FLOAT_WIDTH-1){1'b1}}};

    v2code_sat #(
        .SUM_WIDTH (SW),
        .DAC_WIDTH (DAC_WIDTH)
    ) u_v2code (
        .sum_i  (sum_q),
        .code_o (conv_code),
        .sat_o  (conv_sat)
    );

    always_comb begin
        state_d   = state_q;
        volt_d    = volt_q;
        gain_d    = gain_q;
        off_d     = off_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        sum_d     = sum_q;
        code_d    = code_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        sat_d     = sat_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (enable && SET_VALID) begin
                    volt_d    = SET_VOLTAGE;
                    gain_d    = DAC_CAL_GAIN;
                    off_d     = DAC_CAL_OFFSET;
                    settle_d  = SETTLE_CYCLES;
                    tmo_d     = TIMEOUT_CYCLES;
                    sat_d     = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                prod_d  = prod_sat;
                state_d = ADD;
            end
            ADD: begin
                sum_d   = SW'(prod_q) + SW'(off_q);
                state_d = CONV;
            end
            CONV: begin
                code_d  = conv_code;
                sat_d   = conv_sat;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == settle_q) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT: begin
                // A capture arriving on the final timeout cycle still counts.
                if (ADC_DONE) begin
                    done_d  = 1'b1;
                    state_d = COMPLETE;
                end else if (tmo_q != '0 && cnt_q == tmo_q - 32'd1) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = COMPLETE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort keeps the written code and flags; only pending pulses are dropped.
        if (!enable && state_q != IDLE) begin
            state_d   = IDLE;
            code_d    = code_q;
            sat_d     = sat_q;
            timeout_d = timeout_q;
            cnt_d     = '0;
            start_d   = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            volt_q    <= '0;
            gain_q    <= '0;
            off_q     <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            sum_q     <= '0;
            code_q    <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            volt_q    <= volt_d;
            gain_q    <= gain_d;
            off_q     <= off_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            sum_q     <= sum_d;
            code_q    <= code_d;
            start_q   <= start_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
            timeout_q <= timeout_d;
        end
    end

    assign SET_READY    = (state_q == IDLE) && enable;
    assign DAC_CODE_OUT = code_q;
    assign ADC_START    = start_q;
    assign DONE         = done_q;
    assign SAT          = sat_q;
    assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_dac_seq.sv
// Self-checking bench for dac_seq: directed corner cases plus randomized
// setpoints compared against an arithmetic reference model.
module tb_dac_seq;

    localparam logic [63:0] ONE = 64'h0001_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        set_valid;
    logic [63:0] set_voltage;
    logic        set_ready;
    logic [63:0] gain;
    logic [63:0] offset;
    logic [31:0] settle;
    logic [31:0] tmo;
    logic        adc_done;
    logic [13:0] code;
    logic        adc_start;
    logic        done;
    logic        sat;
    logic        timeout;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [13:0] prev_code;

    always #5 clk = ~clk;

    dac_seq #(
        .FLOAT_WIDTH (64),
        .DAC_WIDTH   (14)
    ) dut (
        .ADC_CLK        (clk),
        .RST            (rst),
        .enable         (enable),
        .SET_VALID      (set_valid),
        .SET_VOLTAGE    (set_voltage),
        .SET_READY      (set_ready),
        .DAC_CAL_GAIN   (gain),
        .DAC_CAL_OFFSET (offset),
        .SETTLE_CYCLES  (settle),
        .TIMEOUT_CYCLES (tmo),
        .ADC_DONE       (adc_done),
        .DAC_CODE_OUT   (code),
        .ADC_START      (adc_start),
        .DONE           (done),
        .SAT            (sat),
        .TIMEOUT        (timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // code = floor((clamp64(V*G in 16Q48) + O) * 8192), clamped to 14 bits
    function automatic logic [13:0] ref_code(input logic signed [63:0] v,
                                             input logic signed [63:0] g,
                                             input logic signed [63:0] o,
                                             output logic is_sat);
        logic signed [127:0] p, s, c, lim_hi, lim_lo;
        lim_hi = (128'sd1 <<< 63) - 128'sd1;
        lim_lo = -(128'sd1 <<< 63);
        p = (128'(v) * 128'(g)) >>> 48;
        if (p > lim_hi) p = lim_hi;
        else if (p < lim_lo) p = lim_lo;
        s = p + 128'(o);
        c = s >>> 35;
        is_sat = 1'b0;
        if (c > 128'sd8191) begin
            c = 128'sd8191;
            is_sat = 1'b1;
        end else if (c < -128'sd8192) begin
            c = -128'sd8192;
            is_sat = 1'b1;
        end
        return c[13:0];
    endfunction

    task automatic start_sp(input logic [63:0] v, input logic [63:0] g, input logic [63:0] o,
                            input int s, input int t, output logic exp_sat);
        logic [13:0] ec;
        ec = ref_code(v, g, o, exp_sat);
        set_voltage = v;
        gain        = g;
        offset      = o;
        settle      = s;
        tmo         = t;
        enable      = 1'b1;
        set_valid   = 1'b1;
        #1;
        check("ready_idle", set_ready, 1);
        tick();
        // Scramble inputs after acceptance: the DUT must use its latched copies.
        set_valid   = 1'b0;
        set_voltage = {$urandom, $urandom};
        gain        = {$urandom, $urandom};
        offset      = {$urandom, $urandom};
        settle      = $urandom;
        tmo         = $urandom;
        adc_done    = 1'($urandom_range(0, 1));
        #1;
        check("ready_busy", set_ready, 0);
        check("sat_clear", sat, 0);
        check("timeout_clear", timeout, 0);
        tick();
        adc_done = 1'($urandom_range(0, 1));
        tick();
        check("code_hold", code, prev_code);
        adc_done = 1'($urandom_range(0, 1));
        tick();
        check("code", code, ec);
        check("sat", sat, exp_sat);
        prev_code = ec;
    endtask

    task automatic wait_start(input int s);
        int k;
        k = 0;
        while (k < s + 20) begin
            adc_done = 1'($urandom_range(0, 1));
            tick();
            k++;
            if (adc_start) break;
        end
        adc_done = 1'b0;
        check("start_latency", k, s + 1);
    endtask

    // d = WAIT cycle on which ADC_DONE is sampled (-1 = never)
    task automatic finish_sp(input int d, input int t);
        int   k, ek;
        logic eto;
        eto = (t != 0) && (d < 0 || t < d);
        ek  = eto ? t : d;
        k   = 0;
        while (k < 60) begin
            adc_done = (k + 1 == d);
            tick();
            k++;
            adc_done = 1'b0;
            if (k == 1) check("start_pulse", adc_start, 0);
            if (done) break;
        end
        check("done_latency", k, ek);
        check("timeout_flag", timeout, eto);
        tick();
        check("done_pulse", done, 0);
        check("ready_again", set_ready, 1);
        check("timeout_sticky", timeout, eto);
    endtask

    initial begin
        logic es;
        logic seen;
        logic [63:0] v, g, o;
        int d, t, s;

        rst = 1'b1; enable = 1'b0; set_valid = 1'b0; adc_done = 1'b0;
        set_voltage = '0; gain = '0; offset = '0; settle = '0; tmo = '0;
        prev_code = '0;
        repeat (3) tick();
        check("rst_code", code, 0);
        check("rst_start", adc_start, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat, 0);
        check("rst_timeout", timeout, 0);
        check("rst_ready_dis", set_ready, 0);
        rst = 1'b0;
        tick();

        // 0.5 V, unity gain
        start_sp(64'h0000_8000_0000_0000, ONE, 64'h0, 0, 0, es);
        check("half_volt", code, 14'h1000);
        wait_start(0);
        finish_sp(1, 0);

        // 2.0 V clamps high, -1.0 V lands exactly on the low limit
        start_sp(64'h0002_0000_0000_0000, ONE, 64'h0, 0, 0, es);
        check("two_volt", code, 14'h1FFF);
        check("two_volt_sat", sat, 1);
        wait_start(0);
        finish_sp(2, 0);
        start_sp(64'hFFFF_0000_0000_0000, ONE, 64'h0, 0, 0, es);
        check("neg_volt", code, 14'h2000);
        check("neg_volt_sat", sat, 0);
        wait_start(0);
        finish_sp(1, 0);

        // settle of 3, capture 5 cycles after start
        start_sp(64'h0000_4000_0000_0000, ONE, 64'h0000_1000_0000_0000, 3, 0, es);
        wait_start(3);
        finish_sp(5, 0);

        // timeout after 10 cycles, then done/timeout collision
        start_sp(64'h0000_2000_0000_0000, ONE, 64'h0, 0, 10, es);
        wait_start(0);
        finish_sp(-1, 10);
        start_sp(64'hFFFF_C000_0000_0000, ONE, 64'h0, 1, 4, es);
        wait_start(1);
        finish_sp(4, 4);

        // enable dropped in SETTLE
        start_sp(64'h0002_0000_0000_0000, ONE, 64'h0, 5, 0, es);
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("abort_start", adc_start, 0);
        check("abort_code", code, 14'h1FFF);
        check("abort_sat", sat, 1);
        enable = 1'b1;
        #1;
        check("abort_idle", set_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (adc_start || done) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);

        // timeout disabled: stay in WAIT, then reset mid-wait
        start_sp(64'h0002_0000_0000_0000, ONE, 64'h0, 0, 0, es);
        wait_start(0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done || set_ready) seen = 1'b1;
        end
        check("wait_forever", seen, 0);
        rst = 1'b1;
        tick();
        check("rst_wait_code", code, 0);
        check("rst_wait_start", adc_start, 0);
        check("rst_wait_done", done, 0);
        check("rst_wait_sat", sat, 0);
        check("rst_wait_timeout", timeout, 0);
        rst = 1'b0;
        prev_code = '0;
        tick();

        for (int i = 0; i < 25; i++) begin
            v = {$urandom, $urandom};
            v = $signed(v) >>> $urandom_range(0, 20);
            case ($urandom_range(0, 2))
                0:       g = ONE;
                1:       begin g = {$urandom, $urandom}; g = $signed(g) >>> $urandom_range(8, 16); end
                default: g = {$urandom, $urandom};
            endcase
            o = {$urandom, $urandom};
            o = $signed(o) >>> $urandom_range(8, 20);
            s = $urandom_range(0, 4);
            d = $urandom_range(1, 8);
            t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8);
            start_sp(v, g, o, s, t, es);
            wait_start(s);
            finish_sp(d, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
